// File: rtl/mmio_led_pwm.sv
// rtl/mmio_led_pwm.sv - memory-mapped multi-channel LED controller with static/PWM modes (optional MMIO_LED_PWM_POLARITY_EN)
module mmio_led_pwm #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          NUM_CH     = 8,
  parameter int          PWM_BITS   = 8,
  parameter int          PRESC_BITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic [3:0]        strobe,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] led
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [5:0]            word;
  logic                  wr;
  logic                  presc_wr;
  logic                  tick;
  logic                  boundary;
  logic [31:0]           bmask;
  logic                  unused_addr;

  logic [NUM_CH-1:0]     out_reg, out_nx;
  logic [NUM_CH-1:0]     mode_reg, mode_nx;
  logic [PRESC_BITS-1:0] presc_reg, presc_nx;
  logic [NUM_CH-1:0]     pol_val;
  logic [PWM_BITS-1:0]   duty_sh  [NUM_CH];
  logic [PWM_BITS-1:0]   duty_nx  [NUM_CH];
  logic [PWM_BITS-1:0]   duty_act [NUM_CH];
  logic [PRESC_BITS-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [NUM_CH-1:0]     pwm_on;

  // Byte-lane merge of a zero-extended register image with the bus write data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
  assign word        = addr[7:2];
  assign wr          = we && hit;
  assign presc_wr    = wr && (word == 6'd2);
  assign bmask       = {{8{strobe[3]}}, {8{strobe[2]}}, {8{strobe[1]}}, {8{strobe[0]}}};
  assign tick        = (presc_cnt == presc_reg);
  assign boundary    = tick && (pwm_cnt == PWM_MAX);
  assign unused_addr = ^addr[1:0];

  // Post-write register values, honouring byte strobes.
  always_comb begin
    logic [31:0] tmp;
    tmp      = merge(32'(out_reg), wdata, bmask);
    out_nx   = (wr && word == 6'd0) ? tmp[NUM_CH-1:0] : out_reg;
    tmp      = merge(32'(mode_reg), wdata, bmask);
    mode_nx  = (wr && word == 6'd1) ? tmp[NUM_CH-1:0] : mode_reg;
    tmp      = merge(32'(presc_reg), wdata, bmask);
    presc_nx = presc_wr ? tmp[PRESC_BITS-1:0] : presc_reg;
    for (int i = 0; i < NUM_CH; i++) begin
      tmp        = merge(32'(duty_sh[i]), wdata, bmask);
      duty_nx[i] = (wr && word == 6'(i + 4)) ? tmp[PWM_BITS-1:0] : duty_sh[i];
    end
  end

  // Control and duty shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg   <= '0;
      mode_reg  <= '0;
      presc_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= '0;
    end else begin
      out_reg   <= out_nx;
      mode_reg  <= mode_nx;
      presc_reg <= presc_nx;
      for (int i = 0; i < NUM_CH; i++) duty_sh[i] <= duty_nx[i];
    end
  end

`ifdef MMIO_LED_PWM_POLARITY_EN
  logic [NUM_CH-1:0] pol_reg;
  logic [31:0]       pol_m;
  assign pol_m   = merge(32'(pol_reg), wdata, bmask);
  assign pol_val = pol_reg;

  // Output polarity register for active-low boards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    pol_reg <= '0;
    else if (wr && word == 6'd3)   pol_reg <= pol_m[NUM_CH-1:0];
  end
`else
  assign pol_val = '0;
`endif

  // Prescaler and PWM counter; a PRESC store restarts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (presc_wr) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // Active duty: resync takes post-write shadows, a period boundary takes the old shadows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
    end else if (presc_wr) begin
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_nx[i];
    end else if (boundary) begin
      for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_sh[i];
    end
  end

  // PWM compare; full-scale duty stays on through the wrap count.
  always_comb begin
    pwm_on = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm_on[i] = (duty_act[i] == PWM_MAX) || (pwm_cnt < duty_act[i]);
  end

  // Registered LED drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= '0;
`ifdef MMIO_LED_PWM_POLARITY_EN
    else        led <= pol_val ^ ((mode_reg & pwm_on) | (~mode_reg & out_reg));
`else
    else        led <= (mode_reg & pwm_on) | (~mode_reg & out_reg);
`endif
  end

  // Read mux; zero outside the window and at unmapped offsets.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (word)
        6'd0:    rdata[NUM_CH-1:0]     = out_reg;
        6'd1:    rdata[NUM_CH-1:0]     = mode_reg;
        6'd2:    rdata[PRESC_BITS-1:0] = presc_reg;
        6'd3:    rdata[NUM_CH-1:0]     = pol_val;
        default: begin
          for (int i = 0; i < NUM_CH; i++)
            if (word == 6'(i + 4)) rdata[PWM_BITS-1:0] = duty_sh[i];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb/tb_mmio_led_pwm.sv - directed self-checking bench for mmio_led_pwm
module tb_mmio_led_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [3:0]  strobe;
  logic        hit;
  logic [7:0]  led;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt;

  mmio_led_pwm dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we),
    .strobe(strobe), .rdata(rdata), .hit(hit), .led(led)
  );

  always #5 clk = ~clk;

  // Clock edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    addr = a; wdata = d; strobe = s; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; addr = 32'h0; strobe = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    #1;
    d = rdata; h = hit;
    addr = 32'h0;
  endtask

  // Counts cycles with led[ch] high; optionally issues one full-word store at cycle wr_at.
  task automatic count_led(input int ch, input int ncyc, input int wr_at,
                           input logic [31:0] wa, input logic [31:0] wd, output int hi);
    hi = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == wr_at) begin
        addr = wa; wdata = wd; strobe = 4'hF; we = 1'b1;
      end else begin
        we = 1'b0; addr = 32'h0; strobe = 4'h0;
      end
      @(posedge clk);
      #1;
      if (led[ch]) hi++;
    end
    we = 1'b0; addr = 32'h0; strobe = 4'h0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          hi;

    rst_n = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; strobe = 4'h0;
    repeat (3) @(negedge clk);
    check("reset_led", {24'h0, led}, 32'h0);
    bus_read(BASE, rd, h);
    check("reset_out", rd, 32'h0);
    check("reset_hit", {31'h0, h}, 32'h1);
    bus_read(BASE + 32'h8, rd, h);
    check("reset_presc", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Static store and registered led stage.
    bus_write(BASE, 32'h0000_00A5, 4'b1111);
    check("led_same_edge", {24'h0, led}, 32'h0);
    @(posedge clk); #1;
    check("led_a5", {24'h0, led}, 32'hA5);
    bus_read(BASE, rd, h);
    check("read_out_a5", rd, 32'hA5);
    check("hit_out", {31'h0, h}, 32'h1);

    // Byte strobes, out-of-window and unmapped accesses.
    bus_write(BASE, 32'hFFFF_FF3C, 4'b0001);
    bus_read(BASE, rd, h);
    check("strobe_b0", rd, 32'h3C);
    bus_write(BASE, 32'h0000_00FF, 4'b1110);
    bus_read(BASE, rd, h);
    check("strobe_no_b0", rd, 32'h3C);
    bus_read(BASE + 32'h4, rd, h);
    check("mode_zero", rd, 32'h0);
    bus_write(32'hFFFE_0000, 32'h0000_00FF, 4'b1111);
    bus_read(32'hFFFE_0000, rd, h);
    check("miss_rdata", rd, 32'h0);
    check("miss_hit", {31'h0, h}, 32'h0);
    bus_read(BASE, rd, h);
    check("miss_no_write", rd, 32'h3C);
    bus_write(BASE + 32'hFC, 32'h1234_5678, 4'b1111);
    bus_read(BASE + 32'hFC, rd, h);
    check("unmapped_read", rd, 32'h0);
    @(posedge clk); #1;
    check("led_3c", {24'h0, led}, 32'h3C);

    // PWM with PRESC=0: 256-cycle period.
    bus_write(BASE + 32'h8,  32'h0, 4'hF);
    bus_write(BASE + 32'h10, 32'd64, 4'hF);
    bus_write(BASE + 32'h4,  32'h1, 4'hF);
    bus_write(BASE + 32'h8,  32'h0, 4'hF);
    count_led(0, 256, -1, 32'h0, 32'h0, hi);
    check("pwm_duty64", hi, 64);
    bus_write(BASE + 32'h10, 32'd0, 4'hF);
    bus_write(BASE + 32'h8,  32'h0, 4'hF);
    count_led(0, 256, -1, 32'h0, 32'h0, hi);
    check("pwm_duty0", hi, 0);
    bus_write(BASE + 32'h10, 32'd255, 4'hF);
    bus_write(BASE + 32'h8,  32'h0, 4'hF);
    count_led(0, 256, -1, 32'h0, 32'h0, hi);
    check("pwm_duty255", hi, 256);

    // PRESC=3: 1024-cycle period, mid-period duty change deferred.
    bus_write(BASE + 32'h18, 32'd128, 4'hF);
    bus_write(BASE + 32'h4,  32'h4, 4'hF);
    bus_write(BASE + 32'h8,  32'h3, 4'hF);
    count_led(2, 1024, 200, BASE + 32'h18, 32'd32, hi);
    check("presc3_keep", hi, 512);
    count_led(2, 1024, -1, 32'h0, 32'h0, hi);
    check("presc3_next", hi, 128);
    bus_write(BASE + 32'h18, 32'd77, 4'hF);
    bus_read(BASE + 32'h18, rd, h);
    check("duty_shadow", rd, 32'd77);
    bus_read(BASE + 32'h8, rd, h);
    check("presc_read", rd, 32'h3);

    // Asynchronous reset mid-period.
    bus_write(BASE + 32'h10, 32'd128, 4'hF);
    bus_write(BASE + 32'h4,  32'h1, 4'hF);
    bus_write(BASE + 32'h8,  32'h0, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_led0", {31'h0, led[0]}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led", {24'h0, led}, 32'h0);
    bus_read(BASE, rd, h);
    check("async_out", rd, 32'h0);
    bus_read(BASE + 32'h4, rd, h);
    check("async_mode", rd, 32'h0);
    bus_read(BASE + 32'h10, rd, h);
    check("async_duty0", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(BASE + 32'h4,  32'h1, 4'hF);
    bus_write(BASE + 32'h10, 32'd255, 4'hF);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (led[0]) break;
    end
    check("restart_first_boundary", edge_cnt, 257);

    // Polarity.
    bus_write(BASE + 32'h4, 32'h0, 4'hF);
    bus_write(BASE,         32'h0F, 4'hF);
    bus_write(BASE + 32'hC, 32'hFF, 4'hF);
    @(posedge clk); #1;
    bus_read(BASE + 32'hC, rd, h);
`ifdef MMIO_LED_PWM_POLARITY_EN
    check("pol_led", {24'h0, led}, 32'hF0);
    check("pol_read", rd, 32'hFF);
`else
    check("pol_led", {24'h0, led}, 32'h0F);
    check("pol_read", rd, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
